// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the mode-3 SPI master.
package spi_pkg;

    localparam int unsigned SCLK_DIV_W = 4;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned CNT_W      = $clog2(DATA_W + 1);

    localparam logic [SCLK_DIV_W-1:0] FRONT_PORCH_LD = 4'b1011;
    localparam logic [SCLK_DIV_W-1:0] SMPL_PT        = 4'b0111;
    localparam logic [SCLK_DIV_W-1:0] SHFT_PT        = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit mode-3 SPI master: one full-duplex transaction per accepted wrt pulse.
module spi_mnrch
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wt_data,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    state_t                state_q, state_d;
    logic [SCLK_DIV_W-1:0] div_q, div_d;
    logic [DATA_W-1:0]     shft_q, shft_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  smpl_q, smpl_d;
    logic                  ss_n_q, ss_n_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '1;
            shft_q    <= '0;
            bit_cnt_q <= '0;
            smpl_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            shft_q    <= shft_d;
            bit_cnt_q <= bit_cnt_d;
            smpl_q    <= smpl_d;
            ss_n_q    <= ss_n_d;
            done_q    <= done_d;
        end
    end

    // Divider free-runs outside IDLE; its MSB is SCLK, so holding it at all ones parks SCLK high.
    always_comb begin
        state_d   = state_q;
        div_d     = SCLK_DIV_W'(div_q + 1'b1);
        shft_d    = shft_q;
        bit_cnt_d = bit_cnt_q;
        smpl_d    = smpl_q;
        ss_n_d    = ss_n_q;
        done_d    = done_q;

        unique case (state_q)
            IDLE: begin
                div_d = '1;
                if (wrt) begin
                    shft_d    = wt_data;
                    ss_n_d    = 1'b0;
                    done_d    = 1'b0;
                    div_d     = FRONT_PORCH_LD;
                    bit_cnt_d = '0;
                    state_d   = FRONT;
                end
            end
            FRONT: begin
                // First SCLK fall carries no shift: MOSI already shows the MSB.
                if (div_q == SHFT_PT) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == SMPL_PT) begin
                    smpl_d    = MISO;
                    bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = BACK;
                    end
                end
                if (div_q == SHFT_PT) begin
                    shft_d = {shft_q[DATA_W-2:0], smpl_q};
                end
            end
            BACK: begin
                // Last shift replaces the divider wrap so SCLK never falls again.
                if (div_q == SHFT_PT) begin
                    shft_d  = {shft_q[DATA_W-2:0], smpl_q};
                    div_d   = '1;
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SCLK    = div_q[SCLK_DIV_W-1];
    assign MOSI    = shft_q[DATA_W-1];
    assign rd_data = shft_q;
    assign SS_n    = ss_n_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_mnrch.sv
// Directed bench for spi_mnrch with a behavioural mode-3 slave.
module tb_spi_mnrch;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        wrt     = 1'b0;
    logic [15:0] wt_data = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] slv_word  = 16'h0000;
    logic [15:0] slv_tx    = 16'h0000;
    logic [15:0] slv_rx    = 16'h0000;
    logic        slv_first = 1'b0;
    logic        ss_prev   = 1'b1;
    logic        sclk_prev = 1'b1;
    int          rises     = 0;
    int          falls     = 0;

    spi_mnrch dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always #5 clk = ~clk;

    // Mode-3 slave: drives its MSB at select, advances on every fall after the first, captures on rise.
    assign MISO = slv_tx[15];

    always @(SS_n or SCLK) begin
        if (ss_prev === 1'b1 && SS_n === 1'b0) begin
            slv_tx    = slv_word;
            slv_first = 1'b1;
            slv_rx    = 16'h0000;
            rises     = 0;
            falls     = 0;
        end else if (SS_n === 1'b0) begin
            if (sclk_prev === 1'b0 && SCLK === 1'b1) begin
                slv_rx = {slv_rx[14:0], MOSI};
                rises++;
            end
            if (sclk_prev === 1'b1 && SCLK === 1'b0) begin
                falls++;
                if (slv_first) slv_first = 1'b0;
                else           slv_tx    = {slv_tx[14:0], 1'b0};
            end
        end
        ss_prev   = SS_n;
        sclk_prev = SCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves time at E0 + 1.
    task automatic start(input logic [15:0] w);
        @(negedge clk);
        wrt     = 1'b1;
        wt_data = w;
        @(posedge clk);
        #1;
        wrt = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", 32'(SS_n), 32'h1);
        chk("rst_sclk", 32'(SCLK), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_mosi", 32'(MOSI), 32'h0);
        chk("rst_rd",   32'(rd_data), 32'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Transfer 1 with an ignored wrt at E100
        slv_word = 16'h3C5A;
        start(16'hA5C3);
        chk("t1_e0_ss_n", 32'(SS_n), 32'h0);
        chk("t1_e0_sclk", 32'(SCLK), 32'h1);
        chk("t1_e0_mosi", 32'(MOSI), 32'h1);
        chk("t1_e0_done", 32'(done), 32'h0);
        step(4);
        chk("t1_e4_sclk", 32'(SCLK), 32'h1);
        step(1);
        chk("t1_e5_sclk", 32'(SCLK), 32'h0);
        chk("t1_e5_mosi", 32'(MOSI), 32'h1);
        step(94);
        @(negedge clk);
        wrt     = 1'b1;
        wt_data = 16'hFFFF;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        step(160);
        chk("t1_e260_done", 32'(done), 32'h0);
        chk("t1_e260_ss_n", 32'(SS_n), 32'h0);
        step(1);
        chk("t1_e261_done",  32'(done), 32'h1);
        chk("t1_e261_ss_n",  32'(SS_n), 32'h1);
        chk("t1_e261_sclk",  32'(SCLK), 32'h1);
        chk("t1_rd_data",    32'(rd_data), 32'h3C5A);
        chk("t1_slv_rx",     32'(slv_rx), 32'hA5C3);
        chk("t1_rises",      32'(rises), 32'd16);
        chk("t1_falls",      32'(falls), 32'd16);

        // Back-to-back transfer accepted at E262
        slv_word = 16'hC3A5;
        start(16'h0F0F);
        chk("t2_e0_done", 32'(done), 32'h0);
        chk("t2_e0_ss_n", 32'(SS_n), 32'h0);
        step(260);
        chk("t2_e260_done", 32'(done), 32'h0);
        step(1);
        chk("t2_e261_done", 32'(done), 32'h1);
        chk("t2_rd_data",   32'(rd_data), 32'hC3A5);
        chk("t2_slv_rx",    32'(slv_rx), 32'h0F0F);
        chk("t2_rises",     32'(rises), 32'd16);

        // Asynchronous reset mid-transfer, while SCLK is low
        slv_word = 16'h1234;
        start(16'hF00F);
        step(119);
        chk("t3_e119_sclk", 32'(SCLK), 32'h0);
        #3;
        rst = 1'b1;
        #1;
        chk("t3_arst_ss_n", 32'(SS_n), 32'h1);
        chk("t3_arst_sclk", 32'(SCLK), 32'h1);
        chk("t3_arst_done", 32'(done), 32'h0);
        chk("t3_arst_mosi", 32'(MOSI), 32'h0);
        chk("t3_arst_rd",   32'(rd_data), 32'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(2);
        chk("t3_post_done", 32'(done), 32'h0);

        // WHO_AM_I read after reset
        slv_word = 16'h006A;
        start(16'h8F00);
        step(261);
        chk("t4_done",     32'(done), 32'h1);
        chk("t4_who_am_i", 32'(rd_data[7:0]), 32'h6A);
        chk("t4_rd_data",  32'(rd_data), 32'h006A);
        chk("t4_slv_rx",   32'(slv_rx), 32'h8F00);
        chk("t4_rises",    32'(rises), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mnrch.md
Name: spi_mnrch

Overview:
- 16-bit SPI master (mode 3: SCLK idles high, MOSI changes on SCLK fall, MISO sampled on SCLK rise).
- Sits directly upstream of the inertial interface. It carries every register write/read between the inertial interface state machine and the IMU in the Segway model.
- One full-duplex 16-bit transaction per wrt pulse.
- done marks completion; rd_data then holds the word shifted in from MISO.

Parameters:
- SCLK_DIV_W, 4: SCLK divider counter width; SCLK period = 2^SCLK_DIV_W clk cycles (16).
- DATA_W, 16: transaction length in bits.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- wrt  input  1  start pulse; sampled only when idle
- wt_data  input  16  word to transmit, MSB first; captured on the clk edge that samples wrt
- done  output  1  registered; high from transaction end until the next accepted wrt
- rd_data  output  16  word received, MSB first; valid while done=1
- SS_n  output  1  active-low slave select (registered)
- SCLK  output  1  serial clock = MSB of divider counter (forced high when idle)
- MOSI  output  1  = shift register MSB
- MISO  input  1  serial data from slave

Behaviour:
- Reset (async, immediate):
  - SS_n=1, SCLK=1, done=0.
  - Shift register=0, so MOSI=0 and rd_data=0.
  - State IDLE, divider=all ones, bit count=0.
- Edges are numbered from E0, the clk edge where wrt is sampled in IDLE.
- States: IDLE, FRONT, SHIFT, BACK.
- IDLE:
  - SCLK=1, SS_n holds its value.
  - On wrt, at E0: shift reg<=wt_data, SS_n<=0, done<=0, divider<=4'b1011, bit count<=0, go FRONT.
  - wrt in any other state is ignored.
- Divider: increments every clk while not IDLE; SCLK = divider[3].
- FRONT:
  - Divider reaches 0000 at E5, so the first SCLK fall is at E5. No shift on this fall; MOSI already shows wt_data[15].
  - Go SHIFT.
- SHIFT, sampling:
  - On the edge where the divider goes 0111->1000 (SCLK rise, E13+16k), sample MISO into a sample flop and increment the bit count.
  - 16th rise occurs at E253.
- SHIFT, shifting:
  - On each edge where the divider goes 1111->0000 (SCLK fall, E21+16k), shift the register left, inserting the sample flop.
  - After the 16th rise, go BACK.
- BACK:
  - At E261 the divider would wrap. Instead: perform the final (16th) shift, hold SCLK high, SS_n<=1, done<=1, go IDLE.
  - rd_data (=shift register) is valid from E261 onward.
- Totals:
  - Exactly 16 SCLK rising edges and 16 falling edges per transaction.
  - SS_n low for 261 clks.
  - The slave sees SS_n low ≥4 clks before the first SCLK fall and ≥8 clks after the last rise.
- Back-to-back: wrt at E261+1 is legal and starts a new E0; done clears on that edge.
- Reset mid-transaction: abort; outputs return to reset values; the slave sees SS_n rise; no partial done.
- done is level, not pulse; consumers edge-detect if needed.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, FRONT, SHIFT, BACK)
  - SCLK_DIV_W
  - FRONT_PORCH_LD (4'b1011)
  - SMPL_PT (4'b0111)
  - SHFT_PT (4'b1111)
  - DATA_W
- No sub-module; single module (~150 lines RTL). The inertial interface instantiates it directly.

Test Plan:
- Reset: hold rst=1 -> SS_n=1, SCLK=1, done=0, MOSI=0, rd_data=16'h0000; assert asynchronously mid-cycle -> outputs change before next clk edge.
- Single transfer: wrt with wt_data=16'hA5C3 against a bench mode-3 slave returning 16'h3C5A -> slave captures 16'hA5C3; rd_data=16'h3C5A; SS_n falls after E0; first SCLK fall at E5; done and SS_n high at E261; exactly 16 rises counted.
- Busy protection: second wrt (wt_data=16'hFFFF) pulsed at E100 -> ignored; transfer 1 results unchanged; done still at E261.
- Back-to-back: wrt at E262 with 16'h0F0F -> done drops at E262; new transfer completes at E262+261; slave receives 16'h0F0F.
- Mid-transfer reset: rst at E120 -> SS_n=1 and SCLK=1 immediately, done=0; after release, wrt 16'h8F00 completes normally.
- Integration with Segway model IMU: wrt 16'h8F00 (WHO_AM_I read) -> rd_data[7:0]=8'h6A.
